mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Each access is latched at grant, held on the memory bus until ack or timeout, then completes.
module mem_port_arbiter #(
    parameter bit DATA_PRIO = 1'b1,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_IF,
        SERVE_D,
        RESP
    } state_e;

    // Last wait-count value before the counter would reach TIMEOUT.
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic [3:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic        served_d_q, served_d_d;
    logic        grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            if_rdata_q <= 16'h0000;
            d_rdata_q  <= 16'h0000;
            wait_q     <= 4'd0;
            err_q      <= 1'b0;
            served_d_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            served_d_q <= served_d_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        wait_d     = wait_q;
        err_d      = err_q;
        served_d_d = served_d_q;
        grant_d    = d_req && (!if_req || DATA_PRIO);

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d    = SERVE_D;
                    we_d       = d_we;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    served_d_d = 1'b1;
                    wait_d     = 4'd0;
                end else if (if_req) begin
                    state_d    = SERVE_IF;
                    we_d       = 1'b0;
                    addr_d     = if_addr;
                    wdata_d    = 16'h0000;
                    served_d_d = 1'b0;
                    wait_d     = 4'd0;
                end
            end
            SERVE_IF, SERVE_D: begin
                // An ack on the timeout edge wins and completes normally.
                if (mem_ack) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (served_d_q) d_rdata_d = mem_rdata;
                        else            if_rdata_d = mem_rdata;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        if (served_d_q) d_rdata_d = 16'h0000;
                        else            if_rdata_d = 16'h0000;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req     = (state_q == SERVE_IF) || (state_q == SERVE_D);
    assign mem_we      = mem_req && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_done     = (state_q == RESP) && !served_d_q;
    assign d_done      = (state_q == RESP) && served_d_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

endmodule
